// File: rtl/eq_share_ctrl.sv
// Round-robin sequencer that time-shares one external CHUNK-bit carry-chained
// equality slice among NREQ requesters, comparing LSB chunk first with early out.
module eq_share_ctrl #(
   parameter  int WIDTH  = 32,
   parameter  int CHUNK  = 2,
   parameter  int NREQ   = 2,
   localparam int IDW    = (NREQ > 2) ? $clog2(NREQ) : 1,
   localparam int NCHUNK = WIDTH / CHUNK
) (
   input  logic                  CLK,
   input  logic                  ASYNCRESETN,
   input  logic [NREQ-1:0]       REQ_VALID,
   output logic [NREQ-1:0]       REQ_READY,
   input  logic [NREQ*WIDTH-1:0] REQ_A,
   input  logic [NREQ*WIDTH-1:0] REQ_B,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic                  RSP_EQ,
   output logic [IDW-1:0]        RSP_ID,
   output logic                  BUSY,
   output logic [CHUNK-1:0]      EQ_I0,
   output logic [CHUNK-1:0]      EQ_I1,
   output logic                  EQ_CI,
   input  logic                  EQ_O
);

   // state | meaning
   // IDLE  | waiting for a request; round-robin grant is offered combinationally
   // CMP   | one chunk per cycle through the shared slice, acc carries running equality
   // RSP   | result held on RSP_EQ/RSP_ID until RSP_READY
   typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;

   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [IW-1:0]    idx;
   logic             acc;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             rsp_eq_q;
   logic [IDW-1:0]   rsp_id_q;

   logic             grant_found;
   logic [IDW-1:0]   grant_id;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         int cand;
         cand = int'(last_grant) + i;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!grant_found && REQ_VALID[cand]) begin
            grant_found = 1'b1;
            grant_id    = IDW'(cand);
         end
      end
   end

   // Gated by reset so no accept strobe is seen while the block is held cleared.
   assign REQ_READY = (ASYNCRESETN && state == IDLE && grant_found)
                      ? (NREQ'(1) << grant_id) : '0;

   assign RSP_VALID = (state == RSP);
   assign RSP_EQ    = rsp_eq_q;
   assign RSP_ID    = rsp_id_q;
   assign BUSY      = (state != IDLE);

   always_comb begin
      EQ_I0 = '0;
      EQ_I1 = '0;
      EQ_CI = 1'b0;
      if (state == CMP) begin
         EQ_I0 = a_q[int'(idx)*CHUNK +: CHUNK];
         EQ_I1 = b_q[int'(idx)*CHUNK +: CHUNK];
         EQ_CI = acc;
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         idx        <= '0;
         acc        <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         rsp_eq_q   <= 1'b0;
         rsp_id_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  a_q        <= REQ_A[int'(grant_id)*WIDTH +: WIDTH];
                  b_q        <= REQ_B[int'(grant_id)*WIDTH +: WIDTH];
                  rsp_id_q   <= grant_id;
                  last_grant <= grant_id;
                  idx        <= '0;
                  acc        <= 1'b1;
                  state      <= CMP;
               end
            end
            CMP: begin
               acc <= EQ_O;
               if (!EQ_O) begin
                  rsp_eq_q <= 1'b0;
                  state    <= RSP;
               end else if (idx == IW'(NCHUNK - 1)) begin
                  rsp_eq_q <= 1'b1;
                  state    <= RSP;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            RSP: begin
               if (RSP_READY) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eq_share_ctrl.sv
// Directed bench for eq_share_ctrl; the external equality slice is modelled here.
module tb_eq_share_ctrl;
   localparam int WIDTH = 32;
   localparam int CHUNK = 2;
   localparam int NREQ  = 2;
   localparam int IDW   = 1;

   logic                  CLK = 1'b0;
   logic                  ASYNCRESETN;
   logic [NREQ-1:0]       REQ_VALID;
   logic [NREQ-1:0]       REQ_READY;
   logic [NREQ*WIDTH-1:0] REQ_A;
   logic [NREQ*WIDTH-1:0] REQ_B;
   logic                  RSP_VALID;
   logic                  RSP_READY;
   logic                  RSP_EQ;
   logic [IDW-1:0]        RSP_ID;
   logic                  BUSY;
   logic [CHUNK-1:0]      EQ_I0;
   logic [CHUNK-1:0]      EQ_I1;
   logic                  EQ_CI;
   logic                  EQ_O;

   eq_share_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK), .NREQ(NREQ)) dut (
      .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_A(REQ_A), .REQ_B(REQ_B),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_EQ(RSP_EQ), .RSP_ID(RSP_ID), .BUSY(BUSY),
      .EQ_I0(EQ_I0), .EQ_I1(EQ_I1), .EQ_CI(EQ_CI), .EQ_O(EQ_O)
   );

   always #5 CLK = ~CLK;

   assign EQ_O = EQ_CI & (EQ_I0 == EQ_I1);

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
      REQ_A[r*WIDTH +: WIDTH] = a;
      REQ_B[r*WIDTH +: WIDTH] = b;
   endtask

   task automatic do_reset;
      ASYNCRESETN = 1'b0;
      REQ_VALID   = '0;
      RSP_READY   = 1'b0;
      tick;
      tick;
      ASYNCRESETN = 1'b1;
      tick;
   endtask

   // Issue one request, return latency from accept edge and the first CMP-cycle slice inputs.
   task automatic run_req(input int r, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [1:0] f0, output logic [1:0] f1,
                          output logic fci);
      logic [1:0] exp_rdy;
      int w;
      set_op(r, a, b);
      REQ_VALID    = '0;
      REQ_VALID[r] = 1'b1;
      #1;
      w = 0;
      while (REQ_READY == '0 && w < 50) begin
         tick;
         w++;
      end
      exp_rdy = 2'b01 << r;
      chk("req_ready", REQ_READY, exp_rdy);
      tick;
      REQ_VALID = '0;
      f0  = EQ_I0;
      f1  = EQ_I1;
      fci = EQ_CI;
      lat = 0;
      while (!RSP_VALID && lat < 40) begin
         tick;
         lat++;
      end
   endtask

   task automatic consume;
      RSP_READY = 1'b1;
      tick;
      RSP_READY = 1'b0;
   endtask

   initial begin
      int lat, w;
      logic [1:0] f0, f1;
      logic fci;

      REQ_A = '0;
      REQ_B = '0;
      REQ_VALID = 2'b01;
      RSP_READY = 1'b0;
      ASYNCRESETN = 1'b0;
      #1;
      chk("rst_req_ready", REQ_READY, 0);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_eq_ci", EQ_CI, 0);
      do_reset;

      // 1: full match on requester 0
      run_req(0, 32'hDEADBEEF, 32'hDEADBEEF, lat, f0, f1, fci);
      chk("match_lat", lat, 16);
      chk("match_eq", RSP_EQ, 1);
      chk("match_id", RSP_ID, 0);
      consume;

      // 2: mismatch in chunk 0 and in chunk 15
      run_req(0, 32'hDEADBEEF, 32'hDEADBEEE, lat, f0, f1, fci);
      chk("mis0_lat", lat, 1);
      chk("mis0_eq", RSP_EQ, 0);
      consume;
      run_req(0, 32'hDEADBEEF, 32'h5EADBEEF, lat, f0, f1, fci);
      chk("mis15_lat", lat, 16);
      chk("mis15_eq", RSP_EQ, 0);
      consume;

      // 3: both requesting, grants alternate starting from 0
      do_reset;
      set_op(0, 32'h12345678, 32'h12345678);
      set_op(1, 32'hABCD0123, 32'hABCD0123);
      REQ_VALID = 2'b11;
      RSP_READY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (!RSP_VALID && w < 60) begin
            tick;
            w++;
         end
         chk("rr_id", RSP_ID, k % 2);
         chk("rr_eq", RSP_EQ, 1);
         tick;
      end
      REQ_VALID = '0;
      RSP_READY = 1'b0;
      tick;

      // 4: back-pressure on the response
      do_reset;
      run_req(0, 32'h0000FFFF, 32'h0000FFFF, lat, f0, f1, fci);
      REQ_VALID = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("hold_valid", RSP_VALID, 1);
         chk("hold_eq", RSP_EQ, 1);
         chk("hold_id", RSP_ID, 0);
         chk("hold_req_ready", REQ_READY, 0);
         chk("hold_busy", BUSY, 1);
         tick;
      end
      consume;
      #1;
      chk("rel_busy", BUSY, 0);
      chk("rel_regrant", REQ_READY, 2'b10);
      REQ_VALID = '0;
      tick;

      // 5: reset in the middle of a compare
      do_reset;
      run_req(1, 32'hCAFEF00D, 32'hCAFEF00D, lat, f0, f1, fci);
      consume;
      set_op(0, 32'h11111111, 32'h11111111);
      REQ_VALID = 2'b01;
      tick;
      REQ_VALID = '0;
      for (int k = 0; k < 7; k++) tick;
      REQ_VALID = 2'b11;
      ASYNCRESETN = 1'b0;
      #1;
      chk("mrst_rsp_valid", RSP_VALID, 0);
      chk("mrst_rsp_eq", RSP_EQ, 0);
      chk("mrst_rsp_id", RSP_ID, 0);
      chk("mrst_busy", BUSY, 0);
      chk("mrst_req_ready", REQ_READY, 0);
      chk("mrst_eq_bus", {EQ_I0, EQ_I1, EQ_CI}, 0);
      tick;
      tick;
      chk("mrst_no_rsp", RSP_VALID, 0);
      ASYNCRESETN = 1'b1;
      #1;
      chk("mrst_first_grant", REQ_READY, 2'b01);
      REQ_VALID = '0;
      tick;

      // 6: first CMP cycle drives the low chunk with carry-in high
      do_reset;
      run_req(0, 32'h00000003, 32'h00000000, lat, f0, f1, fci);
      chk("c6_i0", f0, 2'b11);
      chk("c6_i1", f1, 2'b00);
      chk("c6_ci", fci, 1);
      chk("c6_lat", lat, 1);
      chk("c6_eq", RSP_EQ, 0);
      consume;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
